// File: rtl/axi_write_slave.sv
// axi_write_slave: AXI3 write-channel slave (AW/W/B) terminating single
// outstanding bursts into an internal word-addressed memory, with WSTRB
// byte-lane masking and a combinational debug read port.
//
// Optional feature macro: AXI_WS_RANGE_CHECK_EN
//   defined   : beats whose word index is >= MEM_DEPTH are dropped and flag SLVERR
//   undefined : the word index aliases modulo MEM_DEPTH with no error
module axi_write_slave #(
    parameter int buswidth  = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    // write address channel
    input  logic [3:0]                   AWID,
    input  logic [31:0]                  AWADDR,
    input  logic [3:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic [1:0]                   AWBURST,
    input  logic [1:0]                   AWLOCK,
    input  logic [3:0]                   AWCACHE,
    input  logic [2:0]                   AWPROT,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    // write data channel
    input  logic [3:0]                   WID,
    input  logic [buswidth-1:0]          WDATA,
    input  logic [buswidth/8-1:0]        WSTRB,
    input  logic                         WLAST,
    input  logic                         WVALID,
    output logic                         WREADY,
    // write response channel
    output logic [3:0]                   BID,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    // debug read port
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_idx,
    output logic [buswidth-1:0]          dbg_data
);

    localparam int NB = buswidth / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_n;

    logic [buswidth-1:0] mem [MEM_DEPTH];

    // registered handshake outputs
    logic        awready_q, awready_n;
    logic        wready_q,  wready_n;
    logic        bvalid_q,  bvalid_n;
    logic [3:0]  bid_q,     bid_n;
    logic [1:0]  bresp_q,   bresp_n;

    // captured burst context
    logic [3:0]  id_q,    id_n;
    logic [31:0] addr_q,  addr_n;
    logic [3:0]  len_q,   len_n;
    logic [2:0]  size_q,  size_n;
    logic [1:0]  burst_q, burst_n;
    logic [3:0]  cnt_q,   cnt_n;
    logic        err_q,   err_n;
    logic        sup_q,   sup_n;

    // datapath helpers
    logic        aw_hs, w_hs, b_hs;
    logic        aw_size_bad, aw_burst_bad, aw_wrap_bad;
    logic        last_beat;
    logic        range_bad;
    logic [31:0] beat_step, wrap_len, wrap_mask, addr_inc;
    logic [31:0] word_addr;
    logic        mem_we;
    logic [IW-1:0] mem_idx;

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID  && wready_q;
    assign b_hs  = BREADY  && bvalid_q;

    assign aw_size_bad  = AWSIZE > 3'(LB);
    assign aw_burst_bad = AWBURST == 2'b11;
    assign aw_wrap_bad  = (AWBURST == BURST_WRAP) &&
                          !((AWLEN == 4'd1) || (AWLEN == 4'd3) ||
                            (AWLEN == 4'd7) || (AWLEN == 4'd15));

    assign beat_step = 32'd1 << size_q;
    assign wrap_len  = ({28'd0, len_q} + 32'd1) << size_q;
    assign wrap_mask = wrap_len - 32'd1;
    assign addr_inc  = addr_q + beat_step;
    assign word_addr = addr_q >> LB;
    assign last_beat = cnt_q == len_q;
    assign mem_idx   = word_addr[IW-1:0];

`ifdef AXI_WS_RANGE_CHECK_EN
    assign range_bad = (word_addr >> IW) != 32'd0;
    logic unused_sig;
    assign unused_sig = ^{AWLOCK, AWCACHE, AWPROT};
`else
    assign range_bad = 1'b0;
    logic unused_sig;
    assign unused_sig = ^{AWLOCK, AWCACHE, AWPROT, word_addr[31:IW]};
`endif

    // a beat lands in memory only when the burst is writable and in range
    assign mem_we = (state == DATA) && w_hs && !sup_q && !range_bad;

    // next-state, next-output and burst-context update
    always_comb begin
        state_n   = state;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bid_n     = bid_q;
        bresp_n   = bresp_q;
        id_n      = id_q;
        addr_n    = addr_q;
        len_n     = len_q;
        size_n    = size_q;
        burst_n   = burst_q;
        cnt_n     = cnt_q;
        err_n     = err_q;
        sup_n     = sup_q;

        case (state)
            IDLE: begin
                awready_n = 1'b1;
                wready_n  = 1'b0;
                if (aw_hs) begin
                    id_n      = AWID;
                    addr_n    = AWADDR;
                    len_n     = AWLEN;
                    size_n    = AWSIZE;
                    // illegal-length WRAP is stored as INCR so the beat
                    // address path only has to handle well-formed wraps
                    burst_n   = aw_wrap_bad ? BURST_INCR : AWBURST;
                    cnt_n     = 4'd0;
                    err_n     = aw_size_bad || aw_burst_bad || aw_wrap_bad;
                    sup_n     = aw_size_bad || aw_burst_bad;
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    state_n   = DATA;
                end
            end

            DATA: begin
                if (w_hs) begin
                    cnt_n = cnt_q + 4'd1;
                    err_n = err_q || (WLAST != last_beat) ||
                            (WID != id_q) || range_bad;
                    case (burst_q)
                        BURST_INCR: addr_n = addr_inc;
                        BURST_WRAP: addr_n = (addr_q & ~wrap_mask) |
                                             (addr_inc & wrap_mask);
                        default:    addr_n = addr_q;
                    endcase
                    if (last_beat) begin
                        wready_n = 1'b0;
                        bvalid_n = 1'b1;
                        bid_n    = id_q;
                        bresp_n  = err_n ? RESP_SLVERR : RESP_OKAY;
                        state_n  = RESP;
                    end
                end
            end

            RESP: begin
                if (b_hs) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    state_n   = IDLE;
                end
            end

            default: begin
                state_n   = IDLE;
                awready_n = 1'b1;
                wready_n  = 1'b0;
                bvalid_n  = 1'b0;
            end
        endcase
    end

    // state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // handshake outputs and burst context registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            sup_q     <= 1'b0;
        end else begin
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bid_q     <= bid_n;
            bresp_q   <= bresp_n;
            id_q      <= id_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            size_q    <= size_n;
            burst_q   <= burst_n;
            cnt_q     <= cnt_n;
            err_q     <= err_n;
            sup_q     <= sup_n;
        end
    end

    // byte-lane masked memory write; contents survive reset
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (WSTRB[i]) begin
                    mem[mem_idx][i*8 +: 8] <= WDATA[i*8 +: 8];
                end
            end
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BID      = bid_q;
    assign BRESP    = bresp_q;
    assign dbg_data = mem[dbg_idx];

endmodule

// File: tb/tb_axi_write_slave.sv
// Bench for axi_write_slave: directed bursts with literal expectations plus
// randomized bursts checked against a transaction-level memory/response model.
module tb_axi_write_slave;

    localparam int BW    = 32;
    localparam int DEPTH = 256;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic [1:0]  AWLOCK = '0;
    logic [3:0]  AWCACHE = '0;
    logic [2:0]  AWPROT = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [3:0]  WID = '0;
    logic [BW-1:0] WDATA = '0;
    logic [BW/8-1:0] WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [7:0]  dbg_idx = '0;
    logic [BW-1:0] dbg_data;

    always #5 ACLK = ~ACLK;

    axi_write_slave #(.buswidth(BW), .MEM_DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    int checks = 0;
    int failures = 0;

    // reference memory: value plus per-byte "has been written" mask
    logic [31:0] mmem  [DEPTH];
    logic [3:0]  mknown[DEPTH];
    logic [7:0]  last_idx = '0;
    logic        pause = 1'b1;

    // per-beat stimulus for the next burst
    logic [31:0] bd [16];
    logic [3:0]  bs [16];
    logic [3:0]  bw [16];
    logic        bl [16];
    int gapmin = 0;
    int gapmax = 0;
    int bdly   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no_handshake required=handshake_within_bound", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic prep(input logic [3:0] id, input logic [3:0] len);
        for (int i = 0; i < 16; i++) begin
            bw[i] = id;
            bs[i] = 4'hF;
            bl[i] = (i == int'(len));
            bd[i] = $urandom;
        end
    endtask

    // drive one burst; the model derives every beat address and the response
    // directly from the burst rules. rst_beat >= 0 pulses reset on that beat.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int rst_beat,
                             output logic [1:0] dut_resp, output logic [1:0] mdl_resp);
        int nb;
        logic [31:0] sz, L, lower, a, word;
        logic err, sup, wrapok;
        logic [7:0] idx;
        nb = int'(len) + 1;
        sz = 32'd1 << size;
        sup = (size > 3'd2) || (burst == 2'b11);
        wrapok = (nb == 2) || (nb == 4) || (nb == 8) || (nb == 16);
        err = sup || (burst == 2'b10 && !wrapok);
        for (int i = 0; i < nb; i++)
            if ((bl[i] != (i == nb - 1)) || (bw[i] != id)) err = 1'b1;
        dut_resp = 2'bxx;
        mdl_resp = 2'bxx;

        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len;
        AWSIZE = size; AWBURST = burst;
        for (int c = 0; ; c++) begin
            @(negedge ACLK);
            if (AWREADY) break;
            if (c >= 50) timeout("aw_wait");
        end
        chk("idle_wready_low", {31'd0, WREADY}, 32'd0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;

        for (int i = 0; i < nb; i++) begin
            repeat (gapmin + int'($urandom_range(0, gapmax - gapmin))) begin
                @(posedge ACLK); #1;
            end
            WVALID = 1'b1; WDATA = bd[i]; WSTRB = bs[i]; WID = bw[i]; WLAST = bl[i];
            if (i == rst_beat) begin
                #1 ARESETn = 1'b0;
                #1;
                chk("rst_awready", {31'd0, AWREADY}, 32'd1);
                chk("rst_wready",  {31'd0, WREADY},  32'd0);
                chk("rst_bvalid",  {31'd0, BVALID},  32'd0);
                chk("rst_bid",     {28'd0, BID},     32'd0);
                chk("rst_bresp",   {30'd0, BRESP},   32'd0);
                WVALID = 1'b0; WLAST = 1'b0;
                @(negedge ACLK);
                ARESETn = 1'b1;
                return;
            end
            for (int c = 0; ; c++) begin
                @(negedge ACLK);
                chk("data_awready_low", {31'd0, AWREADY}, 32'd0);
                if (WREADY) break;
                if (c >= 50) timeout("w_wait");
            end
            @(posedge ACLK); #1;
            WVALID = 1'b0; WLAST = 1'b0;
            if (burst == 2'b00) a = addr;
            else if (burst == 2'b10 && wrapok) begin
                L = sz * nb;
                lower = addr - (addr % L);
                a = lower + (((addr % L) + sz * i) % L);
            end else a = addr + sz * i;
            word = a >> 2;
            if (!sup) begin
`ifdef AXI_WS_RANGE_CHECK_EN
                if (word >= DEPTH) err = 1'b1;
                else begin
`else
                begin
`endif
                    idx = word[7:0];
                    for (int b = 0; b < 4; b++)
                        if (bs[i][b]) begin
                            mmem[idx][b*8 +: 8] = bd[i][b*8 +: 8];
                            mknown[idx][b] = 1'b1;
                        end
                    last_idx = idx;
                end
            end
        end

        mdl_resp = err ? 2'b10 : 2'b00;
        @(negedge ACLK);
        dut_resp = BRESP;
        chk("b_wready_low", {31'd0, WREADY}, 32'd0);
        for (int k = 0; k <= bdly; k++) begin
            if (k > 0) @(negedge ACLK);
            chk("b_valid", {31'd0, BVALID}, 32'd1);
            chk("b_id",    {28'd0, BID},    {28'd0, id});
            chk("b_resp",  {30'd0, BRESP},  {30'd0, mdl_resp});
        end
        #1 BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        chk("post_b_bvalid",  {31'd0, BVALID},  32'd0);
        chk("post_b_awready", {31'd0, AWREADY}, 32'd1);
    endtask

    task automatic lit(input string name, input logic [7:0] idx, input logic [31:0] exp);
        pause = 1'b1;
        @(negedge ACLK); #1;
        dbg_idx = idx;
        #1;
        chk({name, "_dut"},   dbg_data,  exp);
        chk({name, "_model"}, mmem[idx], exp);
        pause = 1'b0;
    endtask

    // continuous memory compare against the model on known bytes
    initial begin
        logic [31:0] m;
        forever begin
            @(negedge ACLK);
            if (!pause && ARESETn) begin
                m = {{8{mknown[dbg_idx][3]}}, {8{mknown[dbg_idx][2]}},
                     {8{mknown[dbg_idx][1]}}, {8{mknown[dbg_idx][0]}}};
                if (m != 32'd0) chk("mem_cmp", dbg_data & m, mmem[dbg_idx] & m);
            end
            if (!pause) dbg_idx = ($urandom_range(0, 1) == 1) ? last_idx : 8'($urandom_range(0, DEPTH - 1));
        end
    end

    initial begin
        #2_000_000;
        timeout("watchdog");
    end

    initial begin
        logic [1:0] dr, mr;
        logic [3:0] id, len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [31:0] addr;
        int r;
        for (int i = 0; i < DEPTH; i++) begin
            mknown[i] = 4'h0;
            mmem[i] = '0;
        end

        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_awready", {31'd0, AWREADY}, 32'd1);
        chk("reset_wready",  {31'd0, WREADY},  32'd0);
        chk("reset_bvalid",  {31'd0, BVALID},  32'd0);
        chk("reset_bid",     {28'd0, BID},     32'd0);
        chk("reset_bresp",   {30'd0, BRESP},   32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        pause = 1'b0;

        // single write
        prep(4'd3, 4'd0); bd[0] = 32'hDEADBEEF;
        run_burst(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, -1, dr, mr);
        chk("single_resp", {30'd0, dr}, 32'd0);
        chk("single_resp_model", {30'd0, mr}, 32'd0);
        lit("single_mem4", 8'd4, 32'hDEADBEEF);

        // gapped INCR burst with delayed BREADY
        prep(4'd5, 4'd3);
        for (int i = 0; i < 4; i++) bd[i] = i + 1;
        gapmin = 1; gapmax = 1; bdly = 5;
        run_burst(4'd5, 32'h20, 4'd3, 3'd2, 2'b01, -1, dr, mr);
        chk("incr_resp", {30'd0, dr}, 32'd0);
        for (int i = 0; i < 4; i++) lit("incr_mem", 8'(8 + i), 32'(i + 1));
        gapmin = 0; gapmax = 0; bdly = 0;

        // WRAP burst
        prep(4'd6, 4'd3);
        bd[0] = 32'hA; bd[1] = 32'hB; bd[2] = 32'hC; bd[3] = 32'hD;
        run_burst(4'd6, 32'h38, 4'd3, 3'd2, 2'b10, -1, dr, mr);
        chk("wrap_resp", {30'd0, dr}, 32'd0);
        lit("wrap_mem14", 8'd14, 32'hA);
        lit("wrap_mem15", 8'd15, 32'hB);
        lit("wrap_mem12", 8'd12, 32'hC);
        lit("wrap_mem13", 8'd13, 32'hD);

        // FIXED burst with one-hot strobes
        prep(4'd1, 4'd0); bd[0] = 32'h0;
        run_burst(4'd1, 32'h0, 4'd0, 3'd2, 2'b01, -1, dr, mr);
        prep(4'd2, 4'd3);
        for (int i = 0; i < 4; i++) begin
            bd[i] = 32'h11223344;
            bs[i] = 4'(1 << i);
        end
        run_burst(4'd2, 32'h0, 4'd3, 3'd2, 2'b00, -1, dr, mr);
        chk("fixed_resp", {30'd0, dr}, 32'd0);
        lit("fixed_mem0", 8'd0, 32'h11223344);

        // early WLAST
        prep(4'd4, 4'd3); bl[1] = 1'b1;
        run_burst(4'd4, 32'h100, 4'd3, 3'd2, 2'b01, -1, dr, mr);
        chk("early_wlast_resp", {30'd0, dr}, 32'd2);
        chk("early_wlast_model", {30'd0, mr}, 32'd2);

        // reset mid-burst, then a clean burst
        prep(4'd7, 4'd3);
        run_burst(4'd7, 32'h200, 4'd3, 3'd2, 2'b01, 2, dr, mr);
        prep(4'd8, 4'd1);
        run_burst(4'd8, 32'h240, 4'd1, 3'd2, 2'b01, -1, dr, mr);
        chk("after_reset_resp", {30'd0, dr}, 32'd0);

        // out-of-range word index
        prep(4'd9, 4'd0); bd[0] = 32'h55;
        run_burst(4'd9, 32'h400, 4'd0, 3'd2, 2'b01, -1, dr, mr);
`ifdef AXI_WS_RANGE_CHECK_EN
        chk("range_resp", {30'd0, dr}, 32'd2);
        lit("range_mem0", 8'd0, 32'h11223344);
`else
        chk("range_resp", {30'd0, dr}, 32'd0);
        lit("range_mem0", 8'd0, 32'h00000055);
`endif

        // randomized bursts
        gapmax = 2;
        for (int n = 0; n < 80; n++) begin
            id = 4'($urandom);
            len = 4'($urandom);
            r = int'($urandom_range(0, 9));
            size = (r < 8) ? 3'd2 : 3'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            burst = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
            r = int'($urandom_range(0, 7));
            if (r == 0) addr = $urandom;
            else if (r == 1) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else addr = 32'($urandom_range(0, 32'h3FF));
            prep(id, len);
            for (int i = 0; i < 16; i++) begin
                bs[i] = 4'($urandom);
                if ($urandom_range(0, 15) == 0) bw[i] = id ^ 4'h1;
                if ($urandom_range(0, 19) == 0) bl[i] = ~bl[i];
            end
            bdly = int'($urandom_range(0, 3));
            run_burst(id, addr, len, size, burst, -1, dr, mr);
            chk("rand_resp", {30'd0, dr}, {30'd0, mr});
        end

        repeat (4) @(posedge ACLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_write_slave.md
Name: axi_write_slave

Overview:
- AXI3 write-channel slave that terminates the AW/W/B traffic generated by the write master.
- Accepts one address phase, then absorbs that burst's data beats into an internal word-addressed memory, honouring WSTRB.
- Returns one write response per burst.
- Provides a combinational debug read port so benches and neighbouring blocks can inspect stored data.

Parameters:
- buswidth, 32, WDATA width in bits; legal values 32 and 64; WSTRB width is buswidth/8.
- MEM_DEPTH, 256, number of buswidth-wide memory words; power of two.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- AWID  in  4  write address ID
- AWADDR  in  32  byte start address
- AWLEN  in  4  beats minus one
- AWSIZE  in  3  log2 bytes per beat
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWLOCK/AWCACHE/AWPROT  in  2/4/3  accepted, ignored
- AWVALID  in  1 / AWREADY  out  1  address handshake
- WID  in  4  write data ID
- WDATA  in  buswidth  beat data
- WSTRB  in  buswidth/8  byte lane enables
- WLAST  in  1  last beat marker
- WVALID  in  1 / WREADY  out  1  data handshake
- BID  out  4  response ID
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID  out  1 / BREADY  in  1  response handshake
- dbg_idx  in  log2(MEM_DEPTH)  debug word index
- dbg_data  out  buswidth  combinational memory read at dbg_idx

Behaviour:
- Reset: while ARESETn is low, the block asynchronously forces
  - state to IDLE;
  - AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=00;
  - the beat counter and error flag to 0.
- Memory contents are not reset.
- Reset mid-burst abandons the burst; the next rising edge after release behaves as IDLE.
- All handshake outputs are registered.
- IDLE: AWREADY=1, WREADY=0. On an AWVALID&&AWREADY edge, capture AWID/AWADDR/AWLEN/AWSIZE/AWBURST, clear the beat counter and error flag, and go to DATA. In the next cycle AWREADY=0 and WREADY=1.
- DATA: WREADY=1 and AWREADY=0; W beats are stalled until the address is accepted. On each WVALID&&WREADY edge:
  - For every lane i with WSTRB[i]=1, write byte i of WDATA into mem[idx]; lanes with WSTRB[i]=0 are untouched.
  - idx = (addr >> log2(buswidth/8)) mod MEM_DEPTH.
  - Address update after each beat:
    - FIXED: unchanged.
    - INCR: addr += 1<<AWSIZE.
    - WRAP: addr = (addr & ~(L-1)) | ((addr + (1<<AWSIZE)) & (L-1)), where L = (AWLEN+1)<<AWSIZE.
  - The beat counter increments; the burst ends on the beat where counter==AWLEN. WLAST is checked, not trusted.
- Error flag is set (response SLVERR) when any of the following occurs:
  - WLAST differs from (counter==AWLEN) on any beat;
  - WID != captured AWID;
  - AWSIZE > log2(buswidth/8);
  - AWBURST=11;
  - WRAP with AWLEN not in {1,3,7,15}.
- Writes are suppressed for the whole burst when AWBURST=11 or AWSIZE is illegal. Illegal-length WRAP proceeds as INCR.
- Final beat: in the next cycle WREADY=0, BVALID=1, BID=captured AWID, BRESP = error ? 10 : 00; go to RESP.
- RESP: BVALID/BID/BRESP are held stable until BREADY. On the handshake edge, the next cycle has BVALID=0 and AWREADY=1 (IDLE).
- Minimum burst turnaround is AW + (AWLEN+1) W beats + 1 B cycle; one burst outstanding at a time.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Optional Feature:
- Macro: AXI_WS_RANGE_CHECK_EN.
- Defined: a beat whose (addr >> log2(buswidth/8)) >= MEM_DEPTH is not written and sets the error flag (SLVERR). Remaining beats proceed normally.
- Undefined: the index is taken modulo MEM_DEPTH (aliasing), with no error.

Test Plan:
- Single write: AWID=3, AWADDR=0x10, AWLEN=0, INCR, AWSIZE=2, WDATA=0xDEADBEEF, WSTRB=F, WLAST=1 -> mem[4]=0xDEADBEEF, BID=3, BRESP=00, AWREADY=1 the cycle after the B handshake.
- INCR burst: AWADDR=0x20, AWLEN=3, data 1,2,3,4, WVALID gapped every other cycle, BREADY held low 5 cycles -> mem[8..11]=1..4, BVALID/BID/BRESP stable until BREADY.
- WRAP burst: AWADDR=0x38, AWLEN=3, AWSIZE=2, data A,B,C,D -> mem[14]=A, mem[15]=B, mem[12]=C, mem[13]=D, BRESP=00.
- FIXED strobes: AWADDR=0x0, AWLEN=3, WDATA=0x11223344 each beat, WSTRB=1,2,4,8 on mem[0]=0 -> mem[0]=0x11223344.
- Protocol error and reset: AWLEN=3 with WLAST=1 on beat 1 -> BRESP=10. Separately, ARESETn pulsed low during beat 2 -> WREADY=0, BVALID=0, AWREADY=1 immediately, and a following clean burst gets BRESP=00.
- Range check: MEM_DEPTH=256, AWADDR=0x400, AWLEN=0, data 0x55 -> with the macro: mem[0] unchanged, BRESP=10; without: mem[0]=0x55, BRESP=00.
